// File: rtl/kamacore_pkg.sv
// Shared types and helpers for the kamacore register-file write side.
// Latency: n/a (types, constants and a combinational load formatter only).
// Backpressure: n/a.
//
// Contents: CPU_WIDTH / REG_ADDR_WIDTH / REGISTER_COUNT, load funct3 enum,
// wb_req_t (rd, data) write request, load_extend() byte/half/word formatter.
package kamacore_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REGISTER_COUNT = 1 << REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [CPU_WIDTH-1:0]      data;
  } wb_req_t;

  // Pick the addressed byte/half out of the raw word and extend it.
  // Unlisted funct3 encodings pass the word through unmodified.
  function automatic logic [CPU_WIDTH-1:0] load_extend(
    input logic [2:0]           f3,
    input logic [1:0]           addr_lo,
    input logic [CPU_WIDTH-1:0] rdata
  );
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [CPU_WIDTH-1:0] w_res;
    w_byte = rdata[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      LD_LB:   w_res = {{(CPU_WIDTH-8){w_byte[7]}}, w_byte};
      LD_LH:   w_res = {{(CPU_WIDTH-16){w_half[15]}}, w_half};
      LD_LW:   w_res = rdata;
      LD_LBU:  w_res = {{(CPU_WIDTH-8){1'b0}}, w_byte};
      LD_LHU:  w_res = {{(CPU_WIDTH-16){1'b0}}, w_half};
      default: w_res = rdata;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/kamacore_wb_fifo.sv
// Synchronous FIFO of wb_req_t write requests buffering ALU results.
// Latency: an entry is visible at o_head the cycle after it is pushed.
// Backpressure: o_full reported; pushes when full and pops when empty are ignored.
//
// Ports: clk, rst (async active-low), i_push/i_push_dat, i_pop,
//        o_head (current head entry), o_count, o_full, o_empty.
module kamacore_wb_fifo
  import kamacore_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_req_t                i_push_dat,
  input  logic                   i_pop,
  output wb_req_t                o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t             r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [$clog2(DEPTH):0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == ($clog2(DEPTH)+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kamacore_writeback.sv
// Register-file write port: merges load responses and buffered ALU results,
//   formats load data, and tracks registers with a load outstanding.
// Latency: rd_we/rd_a/rd_data registered, one cycle after the winning source.
// Backpressure: loads never stall; ALU side via alu_ready (FIFO not full).
//
// Ports: clk, rst (async active-low); alu_valid/alu_ready/alu_rd/alu_data;
//   load_issue_valid/load_issue_rd; load_valid/load_rd/load_funct3/
//   load_addr_lo/load_rdata; rs1_a/rs2_a -> rs1_busy/rs2_busy;
//   rd_we/rd_a/rd_data register-file write port.
module kamacore_writeback
  import kamacore_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [CPU_WIDTH-1:0]      alu_data,
  input  logic                      load_issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] load_issue_rd,
  input  logic                      load_valid,
  input  logic [REG_ADDR_WIDTH-1:0] load_rd,
  input  logic [2:0]                load_funct3,
  input  logic [1:0]                load_addr_lo,
  input  logic [CPU_WIDTH-1:0]      load_rdata,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_a,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_a,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rd_we,
  output logic [REG_ADDR_WIDTH-1:0] rd_a,
  output logic [CPU_WIDTH-1:0]      rd_data
);

  wb_req_t w_alu_req;
  wb_req_t w_fifo_head;
  wb_req_t w_win;
  logic    w_win_vld;
  logic    w_alu_push;
  logic    w_bypass;
  logic    w_fifo_push;
  logic    w_fifo_pop;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic [$clog2(ALU_FIFO_DEPTH):0] w_fifo_count;

  logic                      r_rd_we;
  logic [REG_ADDR_WIDTH-1:0] r_rd_a;
  logic [CPU_WIDTH-1:0]      r_rd_data;
  logic [REGISTER_COUNT-1:0] r_pending;
  logic [REGISTER_COUNT-1:0] w_pending_nxt;

  assign w_alu_req = '{rd: alu_rd, data: alu_data};

  // Ready depends only on occupancy, so a full FIFO refuses even while popping.
  assign alu_ready  = !w_fifo_full;
  assign w_alu_push = alu_valid && alu_ready;

  // An ALU result arriving at an idle, empty FIFO goes straight to the write
  // port instead of spending a cycle in storage.
  assign w_bypass    = w_alu_push && w_fifo_empty && !load_valid;
  assign w_fifo_push = w_alu_push && !w_bypass;
  assign w_fifo_pop  = !load_valid && !w_fifo_empty;

  kamacore_wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_fifo_push),
    .i_push_dat (w_alu_req),
    .i_pop      (w_fifo_pop),
    .o_head     (w_fifo_head),
    .o_count    (w_fifo_count),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // Priority: load response, then FIFO head, then the bypassed ALU result.
  always_comb begin
    w_win_vld = 1'b1;
    w_win     = '{rd: load_rd,
                  data: load_extend(load_funct3, load_addr_lo, load_rdata)};
    if (!load_valid) begin
      if (!w_fifo_empty) begin
        w_win = w_fifo_head;
      end else if (w_bypass) begin
        w_win = w_alu_req;
      end else begin
        w_win_vld = 1'b0;
      end
    end
  end

  // x0 targets are consumed like any other result but never enable a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_we   <= 1'b0;
      r_rd_a    <= '0;
      r_rd_data <= '0;
    end else if (w_win_vld) begin
      r_rd_we   <= (w_win.rd != '0);
      r_rd_a    <= w_win.rd;
      r_rd_data <= w_win.data;
    end else begin
      r_rd_we   <= 1'b0;
    end
  end

  // Issue is applied after the response clear so a same-cycle reissue keeps
  // the register marked busy.
  always_comb begin
    w_pending_nxt = r_pending;
    if (load_valid)       w_pending_nxt[load_rd]       = 1'b0;
    if (load_issue_valid) w_pending_nxt[load_issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= w_pending_nxt;
  end

  assign rs1_busy = r_pending[rs1_a];
  assign rs2_busy = r_pending[rs2_a];
  assign rd_we    = r_rd_we;
  assign rd_a     = r_rd_a;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_kamacore_writeback.sv
module tb_kamacore_writeback;
  import kamacore_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_issue_valid;
  logic [4:0]  load_issue_rd;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic [31:0] load_rdata;
  logic [4:0]  rs1_a;
  logic [4:0]  rs2_a;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_we;
  logic [4:0]  rd_a;
  logic [31:0] rd_data;

  int tests = 0;
  int fails = 0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  kamacore_writeback #(.ALU_FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .load_issue_valid (load_issue_valid),
    .load_issue_rd    (load_issue_rd),
    .load_valid       (load_valid),
    .load_rd          (load_rd),
    .load_funct3      (load_funct3),
    .load_addr_lo     (load_addr_lo),
    .load_rdata       (load_rdata),
    .rs1_a            (rs1_a),
    .rs2_a            (rs2_a),
    .rs1_busy         (rs1_busy),
    .rs2_busy         (rs2_busy),
    .rd_we            (rd_we),
    .rd_a             (rd_a),
    .rd_data          (rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_load(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] d);
    load_valid   = v;
    load_rd      = rd;
    load_funct3  = f3;
    load_addr_lo = lo;
    load_rdata   = d;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic idle_inputs();
    set_load(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    load_issue_valid = 1'b0;
    load_issue_rd    = 5'd0;
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    wb_req_t e;
    if (rst && rd_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write", rd_a, rd_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", 32'(rd_a), 32'(e.rd));
        check("wb_data", rd_data, e.data);
      end
    end
  end

  // Load formatting vectors
  logic [2:0]  v_f3  [6] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b011, 3'b001};
  logic [1:0]  v_lo  [6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
  logic [31:0] v_raw [6] = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h0000_8001,
                             32'h0000_AB00, 32'h1234_5678, 32'h7FFF_0000};
  logic [31:0] v_exp [6] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_8001,
                             32'h0000_00AB, 32'h1234_5678, 32'h0000_7FFF};

  // Backpressure sequence: loads hold the port for 4 cycles while ALU offers
  logic       s_lv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       s_av  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [4:0] s_ard [7] = '{5'd20, 5'd21, 5'd22, 5'd22, 5'd22, 5'd22, 5'd0};
  logic       s_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    idle_inputs();
    rs1_a = 5'd9;
    rs2_a = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_we", 32'(rd_we), 32'd0);
    check("reset_rd_a", 32'(rd_a), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_busy", 32'(rs1_busy), 32'd0);
    rst = 1'b1;
    #1;
    check("ready_after_reset", 32'(alu_ready), 32'd1);

    // 1: ALU result into empty FIFO writes next cycle
    set_alu(1'b1, 5'd5, 32'h0000_1234);
    expect_wr(5'd5, 32'h0000_1234);
    tick();
    check("t1_rd_we", 32'(rd_we), 32'd1);
    set_alu(1'b0, 5'd0, 32'd0);

    // 2: load wins over FIFO head rd=3
    set_load(1'b1, 5'd10, 3'b010, 2'd0, 32'hAAAA_5555);
    set_alu(1'b1, 5'd3, 32'h0000_0033);
    expect_wr(5'd10, 32'hAAAA_5555);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_load(1'b1, 5'd11, 3'b010, 2'd0, 32'h1111_1111);
    expect_wr(5'd11, 32'h1111_1111);
    tick();
    set_load(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    expect_wr(5'd3, 32'h0000_0033);
    tick();

    // 3: load formatting
    for (int i = 0; i < 6; i++) begin
      set_load(1'b1, 5'(i + 1), v_f3[i], v_lo[i], v_raw[i]);
      expect_wr(5'(i + 1), v_exp[i]);
      tick();
    end
    set_load(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();

    // 4: FIFO fills behind loads, alu_ready drops, then drains in order
    for (int i = 0; i < 7; i++) begin
      set_load(s_lv[i], 5'(12 + i), 3'b010, 2'd0, 32'h0000_1000 + i);
      if (s_lv[i]) expect_wr(5'(12 + i), 32'h0000_1000 + i);
      set_alu(s_av[i], s_ard[i], 32'(s_ard[i]) << 4);
      if (i == 4) begin
        expect_wr(5'd20, 32'h0000_0140);
        expect_wr(5'd21, 32'h0000_0150);
        expect_wr(5'd22, 32'h0000_0160);
      end
      #1;
      check($sformatf("t4_ready_c%0d", i), 32'(alu_ready), 32'(s_rdy[i]));
      tick();
    end
    idle_inputs();
    tick();

    // 5: pending scoreboard and x0 suppression
    load_issue_valid = 1'b1;
    load_issue_rd    = 5'd7;
    tick();
    load_issue_valid = 1'b0;
    rs1_a = 5'd7;
    rs2_a = 5'd8;
    #1;
    check("t5_rs1_busy", 32'(rs1_busy), 32'd1);
    check("t5_rs2_idle", 32'(rs2_busy), 32'd0);
    rs2_a = 5'd7;
    #1;
    check("t5_rs2_busy", 32'(rs2_busy), 32'd1);
    set_load(1'b1, 5'd7, 3'b010, 2'd0, 32'h0000_0077);
    load_issue_valid = 1'b1;
    expect_wr(5'd7, 32'h0000_0077);
    tick();
    load_issue_valid = 1'b0;
    check("t5_set_wins", 32'(rs1_busy), 32'd1);
    set_load(1'b1, 5'd7, 3'b010, 2'd0, 32'h0000_0078);
    expect_wr(5'd7, 32'h0000_0078);
    tick();
    set_load(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    check("t5_cleared", 32'(rs1_busy), 32'd0);
    load_issue_valid = 1'b1;
    load_issue_rd    = 5'd0;
    tick();
    load_issue_valid = 1'b0;
    rs1_a = 5'd0;
    #1;
    check("t5_x0_never_busy", 32'(rs1_busy), 32'd0);
    set_alu(1'b1, 5'd0, 32'h0000_DEAD);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    check("t5_x0_no_we", 32'(rd_we), 32'd0);
    tick();

    // 6: reset mid-operation drops buffered results and pending bits
    load_issue_valid = 1'b1;
    load_issue_rd    = 5'd9;
    tick();
    load_issue_valid = 1'b0;
    set_load(1'b1, 5'd16, 3'b010, 2'd0, 32'h0000_0016);
    set_alu(1'b1, 5'd24, 32'h0000_0024);
    expect_wr(5'd16, 32'h0000_0016);
    tick();
    set_load(1'b1, 5'd17, 3'b010, 2'd0, 32'h0000_0017);
    set_alu(1'b1, 5'd25, 32'h0000_0025);
    expect_wr(5'd17, 32'h0000_0017);
    tick();
    idle_inputs();
    rs1_a = 5'd9;
    #1;
    check("t6_fifo_full", 32'(alu_ready), 32'd0);
    check("t6_busy_before", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_rd_we", 32'(rd_we), 32'd0);
    check("t6_rst_rd_a", 32'(rd_a), 32'd0);
    check("t6_rst_busy", 32'(rs1_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_ready_after", 32'(alu_ready), 32'd1);
    check("t6_busy_after", 32'(rs1_busy), 32'd0);
    repeat (6) tick();

    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
